// File: rtl/mult_div_unit.sv
// Purpose: multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine for HI/LO.
// Latency: start in cycle 0 -> done in cycle WIDTH+2; divide by zero -> done in cycle 1.
// Backpressure: none; starts while busy are ignored (not queued), results hold until the next op completes.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   start_mult/start_div 1-cycle op requests (multiply wins if both are high)
//   op_a, op_b           multiplicand/dividend and multiplier/divisor, sampled with the start
//   hi_out, lo_out       product {hi,lo}, or remainder (hi) / quotient (lo)
//   busy, done, div_zero status; done and div_zero are 1-cycle registered pulses
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, FIN} state_t;

    state_t           state;
    // acc is one bit wider than the operands so Booth add/subtract of
    // -2^(W-1) and the restoring remainder never overflow.
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mreg;    // multiplicand (sign-extended) or divisor magnitude
    logic [WIDTH-1:0] qreg;    // multiplier / product low half, or dividend / quotient
    logic             qbit;    // Booth q[-1]
    logic [CNT_W-1:0] count;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic             last_step;

    always_comb begin
        // Unsigned W-bit magnitudes: |-2^(W-1)| = 2^(W-1) still fits.
        a_mag = op_a[WIDTH-1] ? -op_a : op_a;
        b_mag = op_b[WIDTH-1] ? -op_b : op_b;

        case ({qreg[0], qbit})
            2'b01:   booth_sum = acc + mreg;
            2'b10:   booth_sum = acc - mreg;
            default: booth_sum = acc;
        endcase

        // Remainder stays below the divisor, so the shifted value fits in W+1 bits;
        // the extra top bit of the trial is the borrow.
        div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {1'b0, mreg};

        fix_q = neg_q ? -qreg : qreg;
        fix_r = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

        last_step = (count == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            mreg     <= '0;
            qreg     <= '0;
            qbit     <= 1'b0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        acc    <= '0;
                        mreg   <= {op_a[WIDTH-1], op_a};
                        qreg   <= op_b;
                        qbit   <= 1'b0;
                        count  <= '0;
                        is_div <= 1'b0;
                        busy   <= 1'b1;
                        state  <= MULT;
                    end else if (start_div) begin
                        busy <= 1'b1;
                        if (op_b == '0) begin
                            // No iterations; results are left untouched.
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= FIN;
                        end else begin
                            acc    <= '0;
                            mreg   <= {1'b0, b_mag};
                            qreg   <= a_mag;
                            count  <= '0;
                            is_div <= 1'b1;
                            neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_r  <= op_a[WIDTH-1];
                            state  <= DIV;
                        end
                    end
                end
                MULT: begin
                    // Arithmetic shift right of {acc, qreg, qbit}.
                    acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    qreg  <= {booth_sum[0], qreg[WIDTH-1:1]};
                    qbit  <= qreg[0];
                    count <= count + 1'b1;
                    if (last_step) state <= FIX;
                end
                DIV: begin
                    if (!div_trial[WIDTH+1]) begin
                        acc  <= div_trial[WIDTH:0];
                        qreg <= {qreg[WIDTH-2:0], 1'b1};
                    end else begin
                        acc  <= div_shift;
                        qreg <= {qreg[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (last_step) state <= FIX;
                end
                FIX: begin
                    // Sign correction is combinational here; the corrected
                    // results land in hi/lo together with done, so they are
                    // visible throughout the FIN cycle.
                    if (is_div) begin
                        hi_out <= fix_r;
                        lo_out <= fix_q;
                    end else begin
                        hi_out <= acc[WIDTH-1:0];
                        lo_out <= qreg;
                    end
                    done  <= 1'b1;
                    state <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose: directed, table-driven check of mult_div_unit plus multi-cycle corner sequences.
// Latency: expects done in cycle 34 (normal) or cycle 1 (divide by zero) after the start cycle.
// Backpressure: exercises ignored starts while busy and reset mid-operation.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Pulses a start for one cycle (cycle 0), then waits for done with a
    // bounded loop. lat is the cycle in which done was seen (100 = timeout).
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_ok);
        @(negedge clock);
        op_a = a; op_b = b; start_mult = m; start_div = d;
        @(negedge clock);
        start_mult = 1'b0; start_div = 1'b0;
        op_a = $urandom; op_b = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clock);
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    // Counts done pulses over n cycles.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (done) cnt++;
        end
    endtask

    initial begin
        int   lat;
        logic bok;
        int   extra;

        vecs[0]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[1]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
        vecs[2]  = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        // divide by zero: hi/lo keep the previous (vecs[2]) results
        vecs[3]  = '{1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1};
        vecs[4]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[5]  = '{1'b1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 34};
        vecs[6]  = '{1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 34};
        vecs[7]  = '{1'b0, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 34};
        vecs[8]  = '{1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 34};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};
        vecs[10] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 34};
        vecs[11] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0, 34};
        vecs[12] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34};

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_hi", hi_out, 32'h0);
        check("reset_lo", lo_out, 32'h0);
        check("reset_status", {29'b0, busy, done, div_zero}, 32'h0);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].is_mult, !vecs[i].is_mult, vecs[i].a, vecs[i].b, lat, bok);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_hi", i), hi_out, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo_out, vecs[i].lo);
            check($sformatf("v%0d_div_zero", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
            check($sformatf("v%0d_busy_during", i), {31'b0, bok}, 32'h1);
            @(negedge clock);
            check($sformatf("v%0d_idle_after", i), {30'b0, busy, done}, 32'h0);
        end

        // Both starts in one cycle: only the multiply runs (3*4, not 3/4)
        run_op(1'b1, 1'b1, 32'd3, 32'd4, lat, bok);
        check("both_latency", 32'(lat), 32'd34);
        check("both_hi", hi_out, 32'h0);
        check("both_lo", lo_out, 32'd12);
        count_done(40, extra);
        check("both_no_second_done", 32'(extra), 32'h0);

        // start_mult while busy with a divide is ignored
        @(negedge clock);
        op_a = 32'd100; op_b = 32'd7; start_div = 1'b1;
        @(negedge clock);
        start_div = 1'b0;
        lat = 1;
        repeat (4) begin @(negedge clock); lat++; end
        op_a = 32'd9; op_b = 32'd9; start_mult = 1'b1;
        @(negedge clock); lat++;
        start_mult = 1'b0;
        while (!done && lat < 100) begin @(negedge clock); lat++; end
        check("busy_start_latency", 32'(lat), 32'd34);
        check("busy_start_hi", hi_out, 32'd2);
        check("busy_start_lo", lo_out, 32'd14);
        count_done(40, extra);
        check("busy_start_not_queued", 32'(extra), 32'h0);

        // Reset in cycle 10 of a divide aborts it without a done pulse
        @(negedge clock);
        op_a = 32'hFFFF_FFF9; op_b = 32'd2; start_div = 1'b1;
        @(negedge clock);
        start_div = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_hi", hi_out, 32'h0);
        check("abort_lo", lo_out, 32'h0);
        count_done(40, extra);
        check("abort_no_done", 32'(extra), 32'h0);

        // Recovery after the abort
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, bok);
        check("recover_latency", 32'(lat), 32'd34);
        check("recover_hi", hi_out, 32'hFFFF_FFFF);
        check("recover_lo", lo_out, 32'hFFFF_FFEB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
